// File: rtl/noc_pipe_mon_if.sv
// noc_if: flit/credit bundle between a router port and the pipe.
// Packet fields (last, addr, data) are qualified by a nonzero vc_target.
interface noc_if #(
    parameter int VC_W = 2,
    parameter int A_W  = 8,
    parameter int D_W  = 8
) ();
    logic [VC_W-1:0] vc_target;
    logic            last;
    logic [A_W-1:0]  addr;
    logic [D_W-1:0]  data;
    logic [VC_W-1:0] vc_credit_gnt;

    modport receiver (
        input  vc_target,
        input  last,
        input  addr,
        input  data,
        output vc_credit_gnt
    );

    modport transmitter (
        output vc_target,
        output last,
        output addr,
        output data,
        input  vc_credit_gnt
    );
endinterface

// File: rtl/noc_pipe_mon.sv
// noc_pipe_mon: latency-configurable NoC flit/credit pipe with an rx-side
// credit monitor, built only when NOC_PIPE_MON_CREDIT_MON_EN is defined.
module noc_pipe_mon #(
    parameter int VC_W        = 2,
    parameter int A_W         = 8,
    parameter int D_W         = 8,
    parameter int FWD_LATENCY = 3,
    parameter int REV_LATENCY = 3,
    parameter int MAX_CREDITS = 8,
    localparam int CNT_W      = $clog2(MAX_CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    noc_if.receiver               from_tx,
    noc_if.transmitter            to_rx,
    input  logic                  err_clr,
    output logic [VC_W*CNT_W-1:0] inflight_cnt,
    output logic [VC_W-1:0]       err_underflow,
    output logic [VC_W-1:0]       err_overflow,
    output logic                  err_multi_vc,
    output logic                  idle
);

    localparam int P_W = 1 + A_W + D_W;

    logic [P_W-1:0] pkt_in;
    logic           fwd_busy;
    logic           rev_busy;
    logic           cnt_busy;

    assign pkt_in = {from_tx.last, from_tx.addr, from_tx.data};

    generate
        if (FWD_LATENCY == 0) begin : g_fwd_comb
            assign to_rx.vc_target = from_tx.vc_target;
            assign {to_rx.last, to_rx.addr, to_rx.data} = pkt_in;
            assign fwd_busy = 1'b0;
        end else begin : g_fwd_pipe
            logic [VC_W-1:0] vc_q  [FWD_LATENCY];
            logic [P_W-1:0]  pkt_q [FWD_LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < FWD_LATENCY; k++)
                        vc_q[k] <= '0;
                end else begin
                    vc_q[0] <= from_tx.vc_target;
                    for (int k = 1; k < FWD_LATENCY; k++)
                        vc_q[k] <= vc_q[k-1];
                end
            end

            // Payload flops carry no reset and only move behind a valid flit.
            always_ff @(posedge clk) begin
                if (|from_tx.vc_target)
                    pkt_q[0] <= pkt_in;
                for (int k = 1; k < FWD_LATENCY; k++)
                    if (|vc_q[k-1])
                        pkt_q[k] <= pkt_q[k-1];
            end

            always_comb begin
                fwd_busy = 1'b0;
                for (int k = 0; k < FWD_LATENCY; k++)
                    fwd_busy = fwd_busy | (|vc_q[k]);
            end

            assign to_rx.vc_target = vc_q[FWD_LATENCY-1];
            assign {to_rx.last, to_rx.addr, to_rx.data} =
                pkt_q[FWD_LATENCY-1];
        end
    endgenerate

    generate
        if (REV_LATENCY == 0) begin : g_rev_comb
            assign from_tx.vc_credit_gnt = to_rx.vc_credit_gnt;
            assign rev_busy = 1'b0;
        end else begin : g_rev_pipe
            logic [VC_W-1:0] gnt_q [REV_LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < REV_LATENCY; k++)
                        gnt_q[k] <= '0;
                end else begin
                    gnt_q[0] <= to_rx.vc_credit_gnt;
                    for (int k = 1; k < REV_LATENCY; k++)
                        gnt_q[k] <= gnt_q[k-1];
                end
            end

            always_comb begin
                rev_busy = 1'b0;
                for (int k = 0; k < REV_LATENCY; k++)
                    rev_busy = rev_busy | (|gnt_q[k]);
            end

            assign from_tx.vc_credit_gnt = gnt_q[REV_LATENCY-1];
        end
    endgenerate

`ifdef NOC_PIPE_MON_CREDIT_MON_EN
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CREDITS);

    logic [VC_W-1:0]  inc;
    logic [VC_W-1:0]  dec;
    logic [CNT_W-1:0] cnt_q [VC_W];
    logic [VC_W-1:0]  ovf_ev;
    logic [VC_W-1:0]  unf_ev;
    logic             mvc_ev;
    logic [VC_W-1:0]  ovf_q;
    logic [VC_W-1:0]  unf_q;
    logic             mvc_q;

    assign inc = to_rx.vc_target;
    assign dec = to_rx.vc_credit_gnt;

    always_comb begin
        ovf_ev = '0;
        unf_ev = '0;
        for (int v = 0; v < VC_W; v++) begin
            ovf_ev[v] = inc[v] & ~dec[v] & (cnt_q[v] == MAX_C);
            unf_ev[v] = dec[v] & ~inc[v] & (cnt_q[v] == '0);
        end
        // x & (x-1) is nonzero iff more than one bit is set.
        mvc_ev = |(inc & (inc - 1'b1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VC_W; v++)
                cnt_q[v] <= '0;
        end else begin
            for (int v = 0; v < VC_W; v++) begin
                if (inc[v] & ~dec[v] & ~ovf_ev[v])
                    cnt_q[v] <= cnt_q[v] + 1'b1;
                else if (dec[v] & ~inc[v] & ~unf_ev[v])
                    cnt_q[v] <= cnt_q[v] - 1'b1;
            end
        end
    end

    // A same-cycle event beats err_clr so no violation is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
            unf_q <= '0;
            mvc_q <= 1'b0;
        end else begin
            ovf_q <= (err_clr ? '0 : ovf_q) | ovf_ev;
            unf_q <= (err_clr ? '0 : unf_q) | unf_ev;
            mvc_q <= (err_clr ? 1'b0 : mvc_q) | mvc_ev;
        end
    end

    always_comb begin
        inflight_cnt = '0;
        cnt_busy     = 1'b0;
        for (int v = 0; v < VC_W; v++) begin
            inflight_cnt[v*CNT_W +: CNT_W] = cnt_q[v];
            cnt_busy = cnt_busy | (|cnt_q[v]);
        end
    end

    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;
    assign err_multi_vc  = mvc_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign inflight_cnt   = '0;
    assign err_overflow   = '0;
    assign err_underflow  = '0;
    assign err_multi_vc   = 1'b0;
    assign cnt_busy       = 1'b0;
`endif

    assign idle = ~fwd_busy & ~rev_busy & ~cnt_busy
                & ~(|to_rx.vc_credit_gnt)
                & ~(|from_tx.vc_target);

endmodule

// File: tb/tb_noc_pipe_mon.sv
// Directed bench for noc_pipe_mon: a FWD=3/REV=2/MAX=4 instance and a
// zero-latency instance; monitor expectations follow the build macro.
module tb_noc_pipe_mon;

`ifdef NOC_PIPE_MON_CREDIT_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic err_clr;

    int tests_run;
    int tests_failed;

    noc_if #(.VC_W(2), .A_W(8), .D_W(8)) a_tx ();
    noc_if #(.VC_W(2), .A_W(8), .D_W(8)) a_rx ();
    noc_if #(.VC_W(2), .A_W(8), .D_W(8)) b_tx ();
    noc_if #(.VC_W(2), .A_W(8), .D_W(8)) b_rx ();

    logic [5:0] a_cnt;
    logic [1:0] a_unf;
    logic [1:0] a_ovf;
    logic       a_mvc;
    logic       a_idle;
    logic [7:0] b_cnt;
    logic [1:0] b_unf;
    logic [1:0] b_ovf;
    logic       b_mvc;
    logic       b_idle;

    noc_pipe_mon #(
        .VC_W(2), .A_W(8), .D_W(8),
        .FWD_LATENCY(3), .REV_LATENCY(2), .MAX_CREDITS(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .from_tx(a_tx.receiver), .to_rx(a_rx.transmitter),
        .err_clr(err_clr), .inflight_cnt(a_cnt),
        .err_underflow(a_unf), .err_overflow(a_ovf),
        .err_multi_vc(a_mvc), .idle(a_idle)
    );

    noc_pipe_mon #(
        .VC_W(2), .A_W(8), .D_W(8),
        .FWD_LATENCY(0), .REV_LATENCY(0), .MAX_CREDITS(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .from_tx(b_tx.receiver), .to_rx(b_rx.transmitter),
        .err_clr(err_clr), .inflight_cnt(b_cnt),
        .err_underflow(b_unf), .err_overflow(b_ovf),
        .err_multi_vc(b_mvc), .idle(b_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic seen;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n   = 1'b0;
        err_clr = 1'b0;
        a_tx.vc_target = '0; a_tx.last = 1'b0;
        a_tx.addr = '0; a_tx.data = '0;
        a_rx.vc_credit_gnt = '0;
        b_tx.vc_target = '0; b_tx.last = 1'b0;
        b_tx.addr = '0; b_tx.data = '0;
        b_rx.vc_credit_gnt = '0;

        // reset state
        #2;
        chk("rst_idle", a_idle, 1);
        chk("rst_vc", a_rx.vc_target, 0);
        chk("rst_gnt", a_tx.vc_credit_gnt, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_err", {a_unf, a_ovf, a_mvc}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // forward/reverse latency
        a_tx.vc_target = 2'b01; a_tx.addr = 8'h05;
        a_tx.data = 8'hA5; a_tx.last = 1'b1;
        tick();
        a_tx.vc_target = 2'b00; a_tx.addr = 8'h00;
        a_tx.data = 8'h00; a_tx.last = 1'b0;
        chk("lat_e1", a_rx.vc_target, 0);
        tick();
        chk("lat_e2", a_rx.vc_target, 0);
        tick();
        chk("lat_vc", a_rx.vc_target, 2'b01);
        chk("lat_pkt", {a_rx.last, a_rx.addr, a_rx.data}, 17'h105A5);
        chk("lat_cnt_pre", a_cnt[2:0], 0);
        tick();
        chk("lat_vc_end", a_rx.vc_target, 0);
        chk("lat_cnt1", a_cnt[2:0], MON ? 1 : 0);
        a_rx.vc_credit_gnt = 2'b01;
        tick();
        a_rx.vc_credit_gnt = 2'b00;
        chk("lat_cnt0", a_cnt[2:0], 0);
        chk("lat_gnt_e1", a_tx.vc_credit_gnt, 0);
        tick();
        chk("lat_gnt", a_tx.vc_credit_gnt, 2'b01);
        tick();
        chk("lat_gnt_end", a_tx.vc_credit_gnt, 0);
        chk("lat_idle", a_idle, 1);

        // payload gating
        a_tx.vc_target = 2'b01; a_tx.data = 8'h11; a_tx.addr = 8'h01;
        #1;
        chk("gate_idle", a_idle, 0);
        tick();
        a_tx.vc_target = 2'b00; a_tx.data = 8'h33;
        tick();
        a_tx.data = 8'h44;
        tick();
        chk("gate_vc1", a_rx.vc_target, 2'b01);
        chk("gate_d1", a_rx.data, 8'h11);
        a_tx.data = 8'h55;
        tick();
        chk("gate_hold_vc", a_rx.vc_target, 0);
        chk("gate_hold_d1", a_rx.data, 8'h11);
        a_tx.data = 8'h66;
        tick();
        chk("gate_hold_d2", a_rx.data, 8'h11);
        a_tx.vc_target = 2'b01; a_tx.data = 8'h22;
        tick();
        a_tx.vc_target = 2'b00; a_tx.data = 8'h77;
        chk("gate_gap", a_rx.vc_target, 0);
        tick();
        tick();
        chk("gate_vc2", a_rx.vc_target, 2'b01);
        chk("gate_d2", a_rx.data, 8'h22);
        tick();
        chk("gate_cnt", a_cnt[2:0], MON ? 2 : 0);
        a_rx.vc_credit_gnt = 2'b01;
        tick();
        tick();
        a_rx.vc_credit_gnt = 2'b00;
        chk("gate_cnt_ret", a_cnt[2:0], 0);
        tick();
        tick();

        // overflow on VC1, MAX_CREDITS=4
        a_tx.vc_target = 2'b10;
        repeat (5) tick();
        a_tx.vc_target = 2'b00;
        tick();
        tick();
        chk("ovf_cnt4", a_cnt[5:3], MON ? 4 : 0);
        chk("ovf_none", a_ovf, 0);
        tick();
        chk("ovf_sat", a_cnt[5:3], MON ? 4 : 0);
        chk("ovf_set", a_ovf, MON ? 2'b10 : 2'b00);
        tick();
        chk("ovf_sticky", a_ovf, MON ? 2'b10 : 2'b00);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr", a_ovf, 0);

        // overflow event in the same cycle as err_clr
        a_tx.vc_target = 2'b10;
        tick();
        a_tx.vc_target = 2'b00;
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr_race", a_ovf, MON ? 2'b10 : 2'b00);
        chk("ovf_race_cnt", a_cnt[5:3], MON ? 4 : 0);

        // drain VC1
        a_rx.vc_credit_gnt = 2'b10;
        repeat (4) tick();
        a_rx.vc_credit_gnt = 2'b00;
        chk("drain_cnt", a_cnt[5:3], 0);
        chk("drain_unf", a_unf, 0);

        // underflow on VC0
        a_rx.vc_credit_gnt = 2'b01;
        tick();
        a_rx.vc_credit_gnt = 2'b00;
        chk("unf_set", a_unf, MON ? 2'b01 : 2'b00);
        chk("unf_cnt", a_cnt[2:0], 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("unf_clr", {a_unf, a_ovf}, 0);

        // inc and dec together at cnt=0
        a_tx.vc_target = 2'b01;
        tick();
        a_tx.vc_target = 2'b00;
        tick();
        tick();
        a_rx.vc_credit_gnt = 2'b01;
        tick();
        a_rx.vc_credit_gnt = 2'b00;
        chk("both_cnt", a_cnt[2:0], 0);
        chk("both_err", {a_unf, a_ovf}, 0);

        // multi-VC flit
        a_tx.vc_target = 2'b11;
        tick();
        a_tx.vc_target = 2'b00;
        tick();
        tick();
        chk("mvc_out", a_rx.vc_target, 2'b11);
        tick();
        chk("mvc_set", a_mvc, MON ? 1 : 0);
        chk("mvc_cnt", a_cnt, MON ? 6'b001001 : 6'b000000);

        // reset with flits in flight
        a_tx.vc_target = 2'b01;
        tick();
        tick();
        tick();
        chk("rstm_pre", a_rx.vc_target, 2'b01);
        rst_n = 1'b0;
        a_tx.vc_target = 2'b00;
        #1;
        chk("rstm_vc", a_rx.vc_target, 0);
        chk("rstm_idle", a_idle, 1);
        chk("rstm_mvc", a_mvc, 0);
        chk("rstm_cnt", a_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen = seen | (|a_rx.vc_target);
        end
        chk("rstm_none", seen, 0);

        // zero-latency instance
        b_tx.vc_target = 2'b10; b_tx.addr = 8'h09;
        b_tx.data = 8'h3C; b_tx.last = 1'b1;
        b_rx.vc_credit_gnt = 2'b01;
        #1;
        chk("z_vc", b_rx.vc_target, 2'b10);
        chk("z_pkt", {b_rx.last, b_rx.addr, b_rx.data}, 17'h1093C);
        chk("z_gnt", b_tx.vc_credit_gnt, 2'b01);
        chk("z_idle", b_idle, 0);
        tick();
        b_tx.vc_target = 2'b00;
        b_rx.vc_credit_gnt = 2'b00;
        #1;
        chk("z_vc_off", b_rx.vc_target, 0);
        chk("z_cnt", b_cnt[7:4], MON ? 1 : 0);
        chk("z_unf", b_unf, MON ? 2'b01 : 2'b00);
        chk("z_ovf", {b_ovf, b_mvc}, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
